// File: rtl/sdl_pixel_stream.sv
// Pixel stream front end: captures the beam sample, tags visible pixels and
// end-of-frame markers, and buffers them in a first-word-fall-through FIFO.
module sdl_pixel_stream #(
  parameter int H_RES      = 640,
  parameter int V_RES      = 480,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          i_clk,
  input  logic                          i_reset,
  input  logic [9:0]                    i_hpos,
  input  logic [9:0]                    i_vpos,
  input  logic                          i_visible,
  input  logic [7:0]                    i_r,
  input  logic [7:0]                    i_g,
  input  logic [7:0]                    i_b,
  output logic                          o_valid,
  input  logic                          i_ready,
  output logic [23:0]                   o_data,
  output logic [3:0]                    o_flags,
  output logic [$clog2(FIFO_DEPTH):0]   o_fill,
  output logic [15:0]                   o_frame_count,
  output logic                          o_overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = AW + 1;
  localparam logic [PW-1:0] FULL_XOR = PW'(FIFO_DEPTH);
  localparam logic [9:0] VSYNC_LINE = 10'(V_RES);

  if (H_RES < 1 || FIFO_DEPTH < 4 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_params
    $error("sdl_pixel_stream: FIFO_DEPTH must be a power of two >= 4 and H_RES >= 1");
  end

  logic [23:0]   cap_rgb_q, cap_rgb_d;
  logic          cap_sol_q, cap_sol_d;
  logic          cap_first_q, cap_first_d;
  logic          cap_vsync_q, cap_vsync_d;
  logic          cap_vis_q, cap_vis_d;

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [15:0]   frame_q, frame_d;
  logic          ovf_q, ovf_d;
  logic [27:0]   mem_q [FIFO_DEPTH];
  logic [27:0]   mem_d [FIFO_DEPTH];

  logic          marker_req;
  logic          push_req;
  logic [27:0]   push_word;
  logic [PW-1:0] fill;
  logic          full;
  logic          valid;
  logic          pop;
  logic          push_ok;
  logic          drop;
  logic [27:0]   head;

  always_comb begin
    cap_rgb_d   = {i_r, i_g, i_b};
    cap_sol_d   = (i_hpos == 10'd0);
    cap_first_d = (i_vpos == 10'd0);
    cap_vsync_d = (i_vpos == VSYNC_LINE);
    cap_vis_d   = i_visible;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      cap_rgb_q   <= '0;
      cap_sol_q   <= 1'b0;
      cap_first_q <= 1'b0;
      cap_vsync_q <= 1'b0;
      cap_vis_q   <= 1'b0;
    end else begin
      cap_rgb_q   <= cap_rgb_d;
      cap_sol_q   <= cap_sol_d;
      cap_first_q <= cap_first_d;
      cap_vsync_q <= cap_vsync_d;
      cap_vis_q   <= cap_vis_d;
    end
  end

  // The marker is the first column of the vsync line, only when it is not itself a visible pixel.
  always_comb begin
    marker_req = ~cap_vis_q & cap_vsync_q & cap_sol_q;
    push_req   = cap_vis_q | marker_req;
    if (cap_vis_q) begin
      push_word = {cap_rgb_q, cap_vis_q, cap_vsync_q, cap_first_q, cap_sol_q};
    end else begin
      push_word = {24'h000000, 4'b0101};
    end
  end

  always_comb begin
    fill    = wr_ptr_q - rd_ptr_q;
    full    = ((wr_ptr_q ^ rd_ptr_q) == FULL_XOR);
    valid   = (fill != '0);
    pop     = valid & i_ready;
    push_ok = push_req & (~full | pop);
    drop    = push_req & full & ~pop;
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q + PW'(push_ok);
    rd_ptr_d = rd_ptr_q + PW'(pop);
    frame_d  = frame_q + 16'(marker_req);
    ovf_d    = ovf_q | drop;
  end

  always_comb begin
    mem_d = mem_q;
    if (push_ok) begin
      mem_d[wr_ptr_q[AW-1:0]] = push_word;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      frame_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      frame_q  <= frame_d;
      ovf_q    <= ovf_d;
    end
  end

  // Storage is not reset; the pointers alone define which entries are live.
  always_ff @(posedge i_clk) begin
    mem_q <= mem_d;
  end

  always_comb begin
    head          = mem_q[rd_ptr_q[AW-1:0]];
    o_valid       = valid;
    o_data        = head[27:4];
    o_flags       = head[3:0];
    o_fill        = fill;
    o_frame_count = frame_q;
    o_overflow    = ovf_q;
  end

endmodule

// File: tb/tb_sdl_pixel_stream.sv
// Testbench for sdl_pixel_stream: queue-based reference model checked every
// cycle, plus directed scenarios with hand-computed expectations.
module tb_sdl_pixel_stream;

  localparam int DEPTH = 16;
  localparam int VRES  = 480;

  logic        clk;
  logic        i_reset;
  logic [9:0]  i_hpos;
  logic [9:0]  i_vpos;
  logic        i_visible;
  logic [7:0]  i_r;
  logic [7:0]  i_g;
  logic [7:0]  i_b;
  logic        o_valid;
  logic        i_ready;
  logic [23:0] o_data;
  logic [3:0]  o_flags;
  logic [4:0]  o_fill;
  logic [15:0] o_frame_count;
  logic        o_overflow;

  int checks = 0;
  int errors = 0;

  sdl_pixel_stream #(
    .H_RES(640),
    .V_RES(VRES),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .i_clk(clk),
    .i_reset(i_reset),
    .i_hpos(i_hpos),
    .i_vpos(i_vpos),
    .i_visible(i_visible),
    .i_r(i_r),
    .i_g(i_g),
    .i_b(i_b),
    .o_valid(o_valid),
    .i_ready(i_ready),
    .o_data(o_data),
    .o_flags(o_flags),
    .o_fill(o_fill),
    .o_frame_count(o_frame_count),
    .o_overflow(o_overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state: what the stream should look like after each edge.
  logic [27:0] model_q[$];
  logic [15:0] model_frames = '0;
  logic        model_ovf    = 1'b0;
  bit          pend_valid   = 1'b0;
  bit          pend_marker  = 1'b0;
  logic [27:0] pend_word    = '0;
  bit          armed        = 1'b0;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Each edge: pop if presented and ready, then offer the previous sample, then classify this sample.
  always @(posedge clk) begin
    if (i_reset) begin
      model_q.delete();
      model_frames = '0;
      model_ovf    = 1'b0;
      pend_valid   = 1'b0;
      pend_marker  = 1'b0;
      armed        = 1'b1;
    end else begin
      if (model_q.size() != 0 && i_ready) void'(model_q.pop_front());
      if (pend_valid) begin
        if (model_q.size() < DEPTH) model_q.push_back(pend_word);
        else model_ovf = 1'b1;
        if (pend_marker) model_frames = model_frames + 16'd1;
      end
      pend_valid  = 1'b0;
      pend_marker = 1'b0;
      if (i_visible) begin
        pend_valid = 1'b1;
        pend_word  = {i_r, i_g, i_b, 1'b1, (i_vpos == 10'(VRES)), (i_vpos == 10'd0), (i_hpos == 10'd0)};
      end else if (i_vpos == 10'(VRES) && i_hpos == 10'd0) begin
        pend_valid  = 1'b1;
        pend_marker = 1'b1;
        pend_word   = {24'h000000, 4'b0101};
      end
    end
  end

  always @(negedge clk) begin
    if (armed) begin
      checkOutput("valid", 32'(o_valid), 32'(model_q.size() != 0));
      checkOutput("fill", 32'(o_fill), 32'(model_q.size()));
      checkOutput("frame_count", 32'(o_frame_count), 32'(model_frames));
      checkOutput("overflow", 32'(o_overflow), 32'(model_ovf));
      if (model_q.size() != 0 && o_valid) begin
        checkOutput("data", 32'(o_data), 32'(model_q[0][27:4]));
        checkOutput("flags", 32'(o_flags), 32'(model_q[0][3:0]));
      end
    end
  end

  task automatic applyStimulus(input logic rst, input logic [9:0] h, input logic [9:0] v,
                               input logic vis, input logic [23:0] rgb, input logic rdy);
    i_reset   = rst;
    i_hpos    = h;
    i_vpos    = v;
    i_visible = vis;
    {i_r, i_g, i_b} = rgb;
    i_ready   = rdy;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic rdy);
    applyStimulus(1'b0, 10'd5, 10'd10, 1'b0, 24'h0, rdy);
  endtask

  initial begin
    logic [9:0] rh;
    logic [9:0] rv;
    int sel;

    i_reset = 1'b1;
    i_hpos = '0; i_vpos = '0; i_visible = 1'b0;
    i_r = '0; i_g = '0; i_b = '0; i_ready = 1'b0;

    $display("[TB] reset");
    for (int i = 0; i < 2; i++)
      applyStimulus(1'b1, 10'($urandom_range(0, 799)), 10'($urandom_range(0, 524)),
                    1'($urandom), 24'($urandom), 1'($urandom));
    checkOutput("rst_valid", 32'(o_valid), 32'd0);
    checkOutput("rst_fill", 32'(o_fill), 32'd0);
    checkOutput("rst_frame", 32'(o_frame_count), 32'd0);
    checkOutput("rst_overflow", 32'(o_overflow), 32'd0);
    idle(1'b1);
    checkOutput("rst_no_push", 32'(o_fill), 32'd0);

    $display("[TB] single pixel");
    applyStimulus(1'b0, 10'd0, 10'd0, 1'b1, 24'h112233, 1'b1);
    checkOutput("px_not_yet", 32'(o_valid), 32'd0);
    idle(1'b1);
    checkOutput("px_valid", 32'(o_valid), 32'd1);
    checkOutput("px_data", 32'(o_data), 32'h112233);
    checkOutput("px_flags", 32'(o_flags), 32'hB);
    idle(1'b1);
    checkOutput("px_popped", 32'(o_valid), 32'd0);

    $display("[TB] marker");
    applyStimulus(1'b0, 10'd0, 10'(VRES), 1'b0, 24'h5A5A5A, 1'b1);
    applyStimulus(1'b0, 10'd1, 10'(VRES), 1'b0, 24'hA5A5A5, 1'b1);
    checkOutput("mk_valid", 32'(o_valid), 32'd1);
    checkOutput("mk_data", 32'(o_data), 32'h0);
    checkOutput("mk_flags", 32'(o_flags), 32'h5);
    checkOutput("mk_frame", 32'(o_frame_count), 32'd1);
    idle(1'b1);
    checkOutput("mk_single", 32'(o_fill), 32'd0);

    $display("[TB] overflow");
    for (int i = 0; i < 17; i++)
      applyStimulus(1'b0, 10'(i + 1), 10'd5, 1'b1, 24'(i), 1'b0);
    idle(1'b0);
    checkOutput("ov_fill", 32'(o_fill), 32'd16);
    checkOutput("ov_flag", 32'(o_overflow), 32'd1);
    for (int i = 0; i < 16; i++) begin
      checkOutput("ov_drain", 32'(o_data), 32'(i));
      idle(1'b1);
    end
    checkOutput("ov_empty", 32'(o_fill), 32'd0);
    checkOutput("ov_sticky", 32'(o_overflow), 32'd1);

    $display("[TB] full push and pop");
    applyStimulus(1'b1, 10'd0, 10'd0, 1'b0, 24'h0, 1'b0);
    for (int i = 0; i < 16; i++)
      applyStimulus(1'b0, 10'(i + 3), 10'd9, 1'b1, 24'(32'h100 + i), 1'b0);
    idle(1'b0);
    checkOutput("fp_fill16", 32'(o_fill), 32'd16);
    applyStimulus(1'b0, 10'd7, 10'd9, 1'b1, 24'hABCDEF, 1'b0);
    idle(1'b1);
    checkOutput("fp_fill_kept", 32'(o_fill), 32'd16);
    checkOutput("fp_no_overflow", 32'(o_overflow), 32'd0);
    for (int i = 1; i < 16; i++) begin
      checkOutput("fp_drain", 32'(o_data), 32'(32'h100 + i));
      idle(1'b1);
    end
    checkOutput("fp_new_last", 32'(o_data), 32'hABCDEF);
    idle(1'b1);
    checkOutput("fp_empty", 32'(o_fill), 32'd0);

    $display("[TB] blanking and reset mid-stream");
    for (int i = 0; i < 100; i++)
      applyStimulus(1'b0, 10'($urandom_range(0, 799)), 10'($urandom_range(0, 479)),
                    1'b0, 24'($urandom), 1'($urandom));
    checkOutput("bl_fill", 32'(o_fill), 32'd0);
    for (int i = 0; i < 5; i++)
      applyStimulus(1'b0, 10'(i + 1), 10'd20, 1'b1, 24'(32'hC0 + i), 1'b0);
    applyStimulus(1'b1, 10'd0, 10'd0, 1'b1, 24'hFFFFFF, 1'b0);
    checkOutput("mr_fill", 32'(o_fill), 32'd0);
    checkOutput("mr_valid", 32'(o_valid), 32'd0);
    idle(1'b1);
    checkOutput("mr_no_push", 32'(o_fill), 32'd0);

    $display("[TB] random traffic");
    for (int i = 0; i < 3000; i++) begin
      sel = int'($urandom_range(0, 3));
      rv = (sel == 0) ? 10'd0 : (sel == 1) ? 10'(VRES) : 10'($urandom_range(0, 524));
      sel = int'($urandom_range(0, 2));
      rh = (sel == 0) ? 10'd0 : 10'($urandom_range(0, 799));
      applyStimulus(($urandom_range(0, 199) == 0), rh, rv, ($urandom_range(0, 9) < 5),
                    24'($urandom), ($urandom_range(0, 9) < 6));
    end
    idle(1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sdl_pixel_stream.md
# sdl_pixel_stream

Downstream consumer of the test-pattern SDL top. Samples the per-clock beam position, visibility and RGB outputs and turns every visible pixel into a FIFO-buffered stream word tagged with line/frame flags. Once per frame it also emits an end-of-frame marker word. The simulator side drains the stream with a valid/ready handshake at its own pace. It does not need to poll the raw counters every clock.

## Interface

Parameters:
- `H_RES`, default 640: active pixels per line (informational; not used for flag generation).
- `V_RES`, default 480: first non-visible line; `vpos == V_RES` is the vsync line.
- `FIFO_DEPTH`, default 16: entries; must be a power of two, ≥ 4.

Ports:
- `i_clk`, in, 1: the single clock.
- `i_reset`, in, 1: synchronous, active-high reset.
- `i_hpos`, in, 10: beam column from the upstream stage.
- `i_vpos`, in, 10: beam row from the upstream stage.
- `i_visible`, in, 1: current pixel is in the active area.
- `i_r`, `i_g`, `i_b`, in, 8 each: current pixel colour.
- `o_valid`, out, 1: the head FIFO entry is presented.
- `i_ready`, in, 1: consumer accepts the head entry when `o_valid` is also high.
- `o_data`, out, 24: head entry colour, `{r,g,b}`.
- `o_flags`, out, 4: head entry flags, `{visible, vsyncLine, firstLine, startOfLine}`.
- `o_fill`, out, $clog2(FIFO_DEPTH)+1: current FIFO occupancy.
- `o_frame_count`, out, 16: number of vsync markers generated since reset.
- `o_overflow`, out, 1: sticky; set when a push is dropped.

## Operation

- **Stage 1 (capture register).** Every clock, register:
  - the RGB inputs;
  - `startOfLine = (i_hpos == 0)`;
  - `firstLine = (i_vpos == 0)`;
  - `vsyncLine = (i_vpos == V_RES)`;
  - `i_visible`.
- **Push request.** A push is requested from the captured values when either condition holds:
  - pixel entry: captured `visible = 1`. Data is the captured RGB; flags are the captured flags.
  - marker entry: captured `visible = 0`, `vsyncLine = 1` and `startOfLine = 1`. Data is `24'h000000`; flags are `4'b0101`.
- **No push.** All other cycles (blanking, non-zero columns of the vsync line) push nothing.
- **Frame counter.** `o_frame_count` increments on every marker push request, whether or not the push is accepted. It wraps from `16'hFFFF` to `0`.
- **FIFO.** Synchronous FIFO of `FIFO_DEPTH` entries, each 28 bits (data + flags).
  - First-word-fall-through: `o_data`/`o_flags` always show the entry at the read pointer. They are don't-care while `o_valid = 0`.
  - `o_valid = (o_fill != 0)`.
  - Pop occurs when `o_valid && i_ready`.
  - Read and write pointers carry `$clog2(FIFO_DEPTH)+1` bits and wrap naturally. Full is detected when the pointers differ only in the MSB.
- **Boundary rules.**
  - Push when not full: accepted.
  - Push when full, no pop the same cycle: entry dropped, `o_overflow` set to 1, `o_fill` unchanged.
  - Push and pop in the same cycle while full: both occur; no overflow; `o_fill` stays at `FIFO_DEPTH`.
  - Push and pop in the same cycle otherwise: both occur; `o_fill` unchanged.
  - Pop when empty: impossible (`o_valid = 0`); `i_ready` is ignored.
  - `o_overflow` clears only on reset.
- **Ordering.** Entries leave in exact push order, and no entry is duplicated.

## Timing

- **Reset values (the cycle after a clock edge with `i_reset = 1`):**
  - `o_valid` = 0, `o_fill` = 0, `o_frame_count` = 0, `o_overflow` = 0;
  - the capture register holds visible = 0 with all flags 0, so it generates no push;
  - FIFO pointers are 0.
- **Reset mid-stream.** All FIFO contents are discarded. No push is generated from inputs sampled on the reset edge. Outputs follow the reset values above.
- **Latency.** A pixel presented in the cycle ending at edge N:
  - is captured at edge N;
  - is written to the FIFO at edge N+1;
  - if the FIFO was empty, `o_valid = 1` with that pixel on `o_data` in the cycle after edge N+1.
- **Throughput.** One push and one pop per clock, sustained. `o_fill` updates at the same edge as the push or pop.
- **Frame counter timing.** `o_frame_count` updates at edge N+1 relative to the marker sample, the same edge as the marker write.

## Test plan

- **Reset:** hold `i_reset = 1` for 2 cycles with random inputs -> `o_valid = 0`, `o_fill = 0`, `o_frame_count = 0`, `o_overflow = 0`.
- **Single pixel:** hpos=0, vpos=0, visible=1, rgb=`0x112233` for one cycle, `i_ready = 1` -> two edges later `o_valid = 1`, `o_data = 0x112233`, `o_flags = 4'b1011`. `o_valid` returns to 0 the next cycle.
- **Marker:** hpos=0, vpos=480, visible=0 for one cycle, then hpos=1 at vpos=480 -> exactly one entry with `o_data = 0`, `o_flags = 4'b0101`; `o_frame_count` goes 0→1.
- **Overflow:** `i_ready = 0`, 17 consecutive visible pixels with rgb = index 0..16 -> `o_fill = 16`, `o_overflow = 1`. Then `i_ready = 1` drains rgb 0..15 in order; `o_overflow` remains 1.
- **Full push+pop:** fill to 16, then one cycle with a visible pixel and `i_ready = 1` -> `o_overflow` stays 0, `o_fill` stays 16. The new pixel eventually appears after the 15 older entries.
- **Blanking and reset mid-stream:** 100 cycles with visible=0 and vpos≠480 -> `o_fill` stays 0. Then push 5 pixels and assert reset -> `o_fill = 0` and `o_valid = 0` next cycle.
